// File: rtl/malzeme_pkg.sv
// Shared types and defaults for the ingredient dispenser.
// Holds the FSM state encoding and the default step/timeout values.
package malzeme_pkg;

  typedef enum logic [2:0] {
    BEKLE = 3'd0,
    UN    = 3'd1,
    SU    = 3'd2,
    TUZ   = 3'd3,
    MAYA  = 3'd4,
    BASLA = 3'd5,
    SONUC = 3'd6
  } durum_t;

  localparam int VARS_SU_ADIM     = 4;
  localparam int VARS_ZAMAN_ASIMI = 15;

endpackage

// File: rtl/malzeme_verici_adim_sayaci.sv
// Saturating step-to-target counter.
// Adds min(step, target-value) per enabled cycle, never passes target.
module adim_sayaci #(
  parameter int W = 8
) (
  input  logic         saat,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] step,
  input  logic [W-1:0] target,
  output logic [W-1:0] value,
  output logic         reached
);

  logic [W-1:0] fark;
  logic [W-1:0] artis;

  // Remaining distance, clamped to the step size
  always_comb begin
    fark  = target - value;
    artis = (fark < step) ? fark : step;
  end

  assign reached = (value == target);

  // Count register: clear on new order, step while enabled and short
  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (enable && !reached) begin
      value <= value + artis;
    end
  end

endmodule

// File: rtl/malzeme_verici.sv
// Ingredient dispenser feeding a dough mixer.
// Dispenses flour, water, salt, yeast, then starts and watches the mixer.
module malzeme_verici
  import malzeme_pkg::*;
#(
  parameter int SU_ADIM     = VARS_SU_ADIM,
  parameter int ZAMAN_ASIMI = VARS_ZAMAN_ASIMI
) (
  input  logic       saat,
  input  logic       reset,
  input  logic       siparis,
  input  logic [5:0] hedef_un,
  input  logic [7:0] hedef_su,
  input  logic [2:0] hedef_tuz,
  input  logic       hedef_maya,
  input  logic       bitti,
  output logic [5:0] un_miktari,
  output logic [7:0] su_miktari,
  output logic [2:0] tuz_miktari,
  output logic       maya,
  output logic       basla,
  output logic       mesgul,
  output logic       tamam,
  output logic       hata
);

  localparam int ZW = $clog2(ZAMAN_ASIMI + 1);
  localparam logic [7:0] SU_STEP = 8'(SU_ADIM);

  durum_t durum, durum_n;

  logic [5:0]    un_h;
  logic [7:0]    su_h;
  logic [2:0]    tuz_h;
  logic          maya_h;
  logic [ZW-1:0] sayac;

  logic kabul;
  logic zaman_doldu;
  logic un_ok, su_ok, tuz_ok;

  assign kabul       = (durum == BEKLE) && siparis;
  assign zaman_doldu = (sayac == ZW'(ZAMAN_ASIMI - 1));
  assign basla       = (durum == BASLA);
  assign mesgul      = (durum != BEKLE);

  adim_sayaci #(.W(6)) u_un (
    .saat    (saat),
    .reset   (reset),
    .clear   (kabul),
    .enable  (durum == UN),
    .step    (6'd1),
    .target  (un_h),
    .value   (un_miktari),
    .reached (un_ok)
  );

  adim_sayaci #(.W(8)) u_su (
    .saat    (saat),
    .reset   (reset),
    .clear   (kabul),
    .enable  (durum == SU),
    .step    (SU_STEP),
    .target  (su_h),
    .value   (su_miktari),
    .reached (su_ok)
  );

  adim_sayaci #(.W(3)) u_tuz (
    .saat    (saat),
    .reset   (reset),
    .clear   (kabul),
    .enable  (durum == TUZ),
    .step    (3'd1),
    .target  (tuz_h),
    .value   (tuz_miktari),
    .reached (tuz_ok)
  );

  // State register
  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      durum <= BEKLE;
    end else begin
      durum <= durum_n;
    end
  end

  // Next-state: each dispense phase ends once its counter hits target
  always_comb begin
    durum_n = durum;
    case (durum)
      BEKLE:   if (siparis) durum_n = UN;
      UN:      if (un_ok) durum_n = SU;
      SU:      if (su_ok) durum_n = TUZ;
      TUZ:     if (tuz_ok) durum_n = MAYA;
      MAYA:    durum_n = BASLA;
      BASLA:   durum_n = SONUC;
      SONUC:   if (bitti || zaman_doldu) durum_n = BEKLE;
      default: durum_n = BEKLE;
    endcase
  end

  // Latched targets, yeast, result flags and mixer timeout counter
  always_ff @(posedge saat or posedge reset) begin
    if (reset) begin
      un_h   <= '0;
      su_h   <= '0;
      tuz_h  <= '0;
      maya_h <= 1'b0;
      maya   <= 1'b0;
      tamam  <= 1'b0;
      hata   <= 1'b0;
      sayac  <= '0;
    end else begin
      tamam <= 1'b0;
      if (kabul) begin
        un_h   <= hedef_un;
        su_h   <= hedef_su;
        tuz_h  <= hedef_tuz;
        maya_h <= hedef_maya;
        maya   <= 1'b0;
        hata   <= 1'b0;
      end
      if (durum == MAYA) begin
        maya <= maya_h;
      end
      if (durum == SONUC) begin
        if (bitti) begin
          tamam <= 1'b1;
        end else if (zaman_doldu) begin
          hata <= 1'b1;
        end
      end
      if (durum == SONUC && !bitti && !zaman_doldu) begin
        sayac <= sayac + 1'b1;
      end else begin
        sayac <= '0;
      end
    end
  end

endmodule

// File: tb/tb_malzeme_verici.sv
// Self-checking bench for malzeme_verici.
// Random and directed orders checked against a cycle-count model.
module tb_malzeme_verici;

  logic       saat = 1'b0;
  logic       reset = 1'b1;
  logic       siparis = 1'b0;
  logic [5:0] hedef_un = '0;
  logic [7:0] hedef_su = '0;
  logic [2:0] hedef_tuz = '0;
  logic       hedef_maya = 1'b0;
  logic       bitti = 1'b0;
  logic [5:0] un_miktari;
  logic [7:0] su_miktari;
  logic [2:0] tuz_miktari;
  logic       maya, basla, mesgul, tamam, hata;

  int gecen = 0;
  int toplam = 0;
  int su_izi[$];

  malzeme_verici dut (
    .saat        (saat),
    .reset       (reset),
    .siparis     (siparis),
    .hedef_un    (hedef_un),
    .hedef_su    (hedef_su),
    .hedef_tuz   (hedef_tuz),
    .hedef_maya  (hedef_maya),
    .bitti       (bitti),
    .un_miktari  (un_miktari),
    .su_miktari  (su_miktari),
    .tuz_miktari (tuz_miktari),
    .maya        (maya),
    .basla       (basla),
    .mesgul      (mesgul),
    .tamam       (tamam),
    .hata        (hata)
  );

  always #5 saat = ~saat;

  // Model: phase lengths are target+1, ceil(water/4)+1, salt+1, then yeast and start
  function automatic int bekl_basla(int u, int s, int t);
    return (u + 1) + ((s + 3) / 4 + 1) + (t + 1) + 2;
  endfunction

  function automatic int paket(int u, int s, int t, int m);
    return (u << 12) | (s << 4) | (t << 1) | m;
  endfunction

  function automatic int cikis();
    return paket(int'(un_miktari), int'(su_miktari), int'(tuz_miktari), int'(maya));
  endfunction

  // Place an order; return the cycle index (1 = first after acceptance) of basla
  task automatic emir(input int u, input int s, input int t, input int m,
                      input bit bozucu, output int n);
    int son;
    @(negedge saat);
    hedef_un   = 6'(u);
    hedef_su   = 8'(s);
    hedef_tuz  = 3'(t);
    hedef_maya = 1'(m);
    siparis    = 1'b1;
    @(negedge saat);
    siparis = 1'b0;
    n = 1;
    son = 0;
    su_izi.delete();
    while (basla !== 1'b1 && n < 400) begin
      if (int'(su_miktari) != son) begin
        su_izi.push_back(int'(su_miktari));
        son = int'(su_miktari);
      end
      if (bozucu) begin
        siparis    = 1'($urandom);
        hedef_un   = 6'($urandom);
        hedef_su   = 8'($urandom);
        hedef_tuz  = 3'($urandom);
        hedef_maya = 1'($urandom);
        bitti      = 1'($urandom);
      end
      @(negedge saat);
      n++;
    end
    siparis = 1'b0;
    bitti   = 1'b0;
  endtask

  // From the basla cycle, raise bitti d cycles later for one cycle
  task automatic bitti_ver(input int d);
    repeat (d) @(negedge saat);
    bitti = 1'b1;
    @(negedge saat);
    bitti = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    toplam++;
    if (cikis() !== 0) $display("FAIL reset_miktar: got %h expected 0", cikis());
    else gecen++;
    toplam++;
    if ({basla, mesgul, tamam, hata} !== 4'b0)
      $display("FAIL reset_bayrak: got %b expected 0000", {basla, mesgul, tamam, hata});
    else gecen++;
    @(negedge saat);
    reset = 1'b0;
  endtask

  task automatic test_ornek();
    int n;
    emir(3, 10, 2, 1, 0, n);
    toplam++;
    if (n !== bekl_basla(3, 10, 2)) $display("FAIL ornek_basla: got %0d expected %0d", n, bekl_basla(3, 10, 2));
    else gecen++;
    toplam++;
    if (n !== 13) $display("FAIL ornek_basla13: got %0d expected 13", n);
    else gecen++;
    toplam++;
    if (cikis() !== paket(3, 10, 2, 1)) $display("FAIL ornek_miktar: got %h expected %h", cikis(), paket(3, 10, 2, 1));
    else gecen++;
    bitti_ver(2);
    toplam++;
    if ({tamam, hata, mesgul} !== 3'b100) $display("FAIL ornek_tamam: got %b expected 100", {tamam, hata, mesgul});
    else gecen++;
    @(negedge saat);
    toplam++;
    if (tamam !== 1'b0) $display("FAIL ornek_tamam_tek: got %b expected 0", tamam);
    else gecen++;
    repeat (3) @(negedge saat);
    toplam++;
    if (cikis() !== paket(3, 10, 2, 1)) $display("FAIL ornek_tutma: got %h expected %h", cikis(), paket(3, 10, 2, 1));
    else gecen++;
  endtask

  task automatic test_sifir();
    int n;
    emir(0, 0, 0, 0, 0, n);
    toplam++;
    if (n !== 5) $display("FAIL sifir_basla: got %0d expected 5", n);
    else gecen++;
    toplam++;
    if (cikis() !== 0) $display("FAIL sifir_miktar: got %h expected 0", cikis());
    else gecen++;
    bitti_ver(1);
    toplam++;
    if (tamam !== 1'b1) $display("FAIL sifir_tamam: got %b expected 1", tamam);
    else gecen++;
  endtask

  task automatic test_tasma();
    int n, v;
    int bek[$];
    bit esit;
    emir(63, 255, 7, 1, 0, n);
    v = 0;
    while (v < 255) begin
      v = (v + 4 > 255) ? 255 : v + 4;
      bek.push_back(v);
    end
    esit = (bek.size() == su_izi.size());
    if (esit) foreach (bek[i]) if (bek[i] != su_izi[i]) esit = 0;
    toplam++;
    if (!esit) $display("FAIL tasma_su_dizisi: got %0d steps last %0d expected %0d steps last 255",
                        su_izi.size(), (su_izi.size() > 0) ? su_izi[$] : -1, bek.size());
    else gecen++;
    toplam++;
    if (n !== bekl_basla(63, 255, 7)) $display("FAIL tasma_basla: got %0d expected %0d", n, bekl_basla(63, 255, 7));
    else gecen++;
    toplam++;
    if (cikis() !== paket(63, 255, 7, 1)) $display("FAIL tasma_miktar: got %h expected %h", cikis(), paket(63, 255, 7, 1));
    else gecen++;
    bitti_ver(1);
    toplam++;
    if (tamam !== 1'b1) $display("FAIL tasma_tamam: got %b expected 1", tamam);
    else gecen++;
  endtask

  task automatic test_zaman_asimi();
    int n;
    emir(5, 20, 3, 0, 0, n);
    repeat (15) @(negedge saat);
    toplam++;
    if ({hata, mesgul} !== 2'b01) $display("FAIL zaman_once: got %b expected 01", {hata, mesgul});
    else gecen++;
    @(negedge saat);
    toplam++;
    if ({hata, mesgul, tamam} !== 3'b100) $display("FAIL zaman_hata: got %b expected 100", {hata, mesgul, tamam});
    else gecen++;
    repeat (3) @(negedge saat);
    toplam++;
    if (hata !== 1'b1) $display("FAIL zaman_yapiskan: got %b expected 1", hata);
    else gecen++;
    emir(1, 1, 1, 1, 0, n);
    toplam++;
    if (hata !== 1'b0) $display("FAIL zaman_temizle: got %b expected 0", hata);
    else gecen++;
    bitti_ver(1);
    toplam++;
    if ({tamam, hata} !== 2'b10) $display("FAIL zaman_sonra_tamam: got %b expected 10", {tamam, hata});
    else gecen++;
  endtask

  task automatic test_reset_ara();
    int n, k;
    @(negedge saat);
    hedef_un = 6'd10; hedef_su = 8'd100; hedef_tuz = 3'd3; hedef_maya = 1'b1;
    siparis = 1'b1;
    @(negedge saat);
    siparis = 1'b0;
    k = 0;
    while (su_miktari == 8'd0 && k < 50) begin
      @(negedge saat);
      k++;
    end
    toplam++;
    if (su_miktari === 8'd0) $display("FAIL ara_su_baslamadi: got %0d expected nonzero", su_miktari);
    else gecen++;
    reset = 1'b1;
    #1;
    toplam++;
    if (cikis() !== 0) $display("FAIL ara_reset_miktar: got %h expected 0", cikis());
    else gecen++;
    toplam++;
    if ({basla, mesgul, tamam, hata} !== 4'b0)
      $display("FAIL ara_reset_bayrak: got %b expected 0000", {basla, mesgul, tamam, hata});
    else gecen++;
    @(negedge saat);
    reset = 1'b0;
    emir(2, 9, 1, 0, 0, n);
    toplam++;
    if (n !== bekl_basla(2, 9, 1)) $display("FAIL ara_sonra_basla: got %0d expected %0d", n, bekl_basla(2, 9, 1));
    else gecen++;
    toplam++;
    if (cikis() !== paket(2, 9, 1, 0)) $display("FAIL ara_sonra_miktar: got %h expected %h", cikis(), paket(2, 9, 1, 0));
    else gecen++;
    bitti_ver(1);
    toplam++;
    if (tamam !== 1'b1) $display("FAIL ara_sonra_tamam: got %b expected 1", tamam);
    else gecen++;
  endtask

  task automatic test_mesgul();
    int n;
    emir(4, 30, 5, 1, 1, n);
    toplam++;
    if (n !== bekl_basla(4, 30, 5)) $display("FAIL mesgul_basla: got %0d expected %0d", n, bekl_basla(4, 30, 5));
    else gecen++;
    toplam++;
    if (cikis() !== paket(4, 30, 5, 1)) $display("FAIL mesgul_miktar: got %h expected %h", cikis(), paket(4, 30, 5, 1));
    else gecen++;
    bitti_ver(1);
    toplam++;
    if ({tamam, hata} !== 2'b10) $display("FAIL mesgul_tamam: got %b expected 10", {tamam, hata});
    else gecen++;
  endtask

  task automatic test_rastgele();
    int n, u, s, t, m, d;
    for (int i = 0; i < 8; i++) begin
      u = int'($urandom_range(0, 63));
      s = int'($urandom_range(0, 255));
      t = int'($urandom_range(0, 7));
      m = int'($urandom_range(0, 1));
      d = int'($urandom_range(1, 6));
      emir(u, s, t, m, i[0], n);
      toplam++;
      if (n !== bekl_basla(u, s, t)) $display("FAIL rastgele_basla[%0d]: got %0d expected %0d", i, n, bekl_basla(u, s, t));
      else gecen++;
      toplam++;
      if (cikis() !== paket(u, s, t, m)) $display("FAIL rastgele_miktar[%0d]: got %h expected %h", i, cikis(), paket(u, s, t, m));
      else gecen++;
      bitti_ver(d);
      toplam++;
      if ({tamam, hata, mesgul} !== 3'b100) $display("FAIL rastgele_tamam[%0d]: got %b expected 100", i, {tamam, hata, mesgul});
      else gecen++;
    end
  endtask

  initial begin
    test_reset();
    test_ornek();
    test_sifir();
    test_tasma();
    test_zaman_asimi();
    test_reset_ara();
    test_mesgul();
    test_rastgele();
    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule
